// File: rtl/wallace_tree_reduction_if.sv
// Operand/product bundle for the 5x5 Wallace tree multiplier.
// The master drives the operands A and B; the slave returns the registered product P.
interface wallace_tree_reduction_if;
    logic [4:0] A;
    logic [4:0] B;
    logic [9:0] P;

    modport master (output A, output B, input P);
    modport slave (input A, input B, output P);
endinterface

// File: rtl/wallace_tree_reduction.sv
// 5x5 unsigned Wallace tree multiplier with a registered 10-bit product.
// Define WALLACE_PIPE_EN to register the two reduced rows ahead of the final ripple adder.
module wallace_tree_reduction (
    input  logic                     clk,
    input  logic                     rst_n,
    wallace_tree_reduction_if.slave  bus
);

    // Columns 0..8 hold partial-product bits; column 9 only ever gets the adder carry-out.
    typedef struct packed {
        logic [8:0][5:0] bits;
        logic [8:0][2:0] hgt;
    } tree_t;

    function automatic tree_t push_bit(input tree_t t, input logic [3:0] c, input logic b);
        tree_t r;
        r = t;
        r.bits[c][r.hgt[c]] = b;
        r.hgt[c] = r.hgt[c] + 3'd1;
        return r;
    endfunction

    // One Wallace stage: every column taller than two is cut into 3:2 groups, and a
    // leftover pair goes through a 2:2; shorter columns pass untouched.
    function automatic tree_t wallace_stage(input tree_t cur);
        tree_t      nxt;
        logic [2:0] h;
        logic [2:0] k;
        logic       x;
        logic       y;
        logic       z;
        nxt = '0;
        for (int c = 0; c < 9; c++) begin
            h = cur.hgt[4'(c)];
            k = 3'd0;
            if (h > 3'd2 && c < 8) begin
                for (int g = 0; g < 2; g++) begin
                    if (k + 3'd3 <= h) begin
                        x = cur.bits[4'(c)][k];
                        y = cur.bits[4'(c)][k + 3'd1];
                        z = cur.bits[4'(c)][k + 3'd2];
                        nxt = push_bit(nxt, 4'(c), x ^ y ^ z);
                        nxt = push_bit(nxt, 4'(c + 1), (x & y) | (x & z) | (y & z));
                        k = k + 3'd3;
                    end
                end
                if (h - k == 3'd2) begin
                    x = cur.bits[4'(c)][k];
                    y = cur.bits[4'(c)][k + 3'd1];
                    nxt = push_bit(nxt, 4'(c), x ^ y);
                    nxt = push_bit(nxt, 4'(c + 1), x & y);
                    k = k + 3'd2;
                end
            end
            for (int j = 0; j < 6; j++) begin
                if (3'(j) >= k && 3'(j) < h) begin
                    nxt = push_bit(nxt, 4'(c), cur.bits[4'(c)][3'(j)]);
                end
            end
        end
        return nxt;
    endfunction

    // Column heights go 5 -> 4 -> 3 -> 2 over the three stages; returns {row1, row0}.
    function automatic logic [17:0] reduce_rows(input logic [4:0] a, input logic [4:0] b);
        tree_t      t;
        logic [8:0] r0;
        logic [8:0] r1;
        t = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                t = push_bit(t, 4'(i + j), a[3'(j)] & b[3'(i)]);
            end
        end
        for (int s = 0; s < 3; s++) begin
            t = wallace_stage(t);
        end
        r0 = '0;
        r1 = '0;
        for (int c = 0; c < 9; c++) begin
            if (t.hgt[4'(c)] > 3'd0) begin
                r0[4'(c)] = t.bits[4'(c)][0];
            end
            if (t.hgt[4'(c)] > 3'd1) begin
                r1[4'(c)] = t.bits[4'(c)][1];
            end
        end
        return {r1, r0};
    endfunction

    function automatic logic [9:0] ripple_add(input logic [8:0] x, input logic [8:0] y);
        logic [8:0] s;
        logic       carry;
        carry = 1'b0;
        for (int c = 0; c < 9; c++) begin
            s[4'(c)] = x[4'(c)] ^ y[4'(c)] ^ carry;
            carry    = (x[4'(c)] & y[4'(c)]) | (carry & (x[4'(c)] ^ y[4'(c)]));
        end
        return {carry, s};
    endfunction

    logic [8:0] row0_d;
    logic [8:0] row1_d;
    logic [9:0] sum_d;
    logic [9:0] p_q;

    assign {row1_d, row0_d} = reduce_rows(bus.A, bus.B);

`ifdef WALLACE_PIPE_EN
    logic [8:0] row0_q;
    logic [8:0] row1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row0_q <= '0;
            row1_q <= '0;
        end else begin
            row0_q <= row0_d;
            row1_q <= row1_d;
        end
    end

    assign sum_d = ripple_add(row0_q, row1_q);
`else
    assign sum_d = ripple_add(row0_d, row1_d);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= sum_d;
        end
    end

    assign bus.P = p_q;

endmodule

// File: tb/tb_wallace_tree_reduction.sv
// Scoreboard bench for wallace_tree_reduction: expected products queue up as operands are
// driven and are compared once the configured latency has elapsed.
`timescale 1ns/1ps
module tb_wallace_tree_reduction;

`ifdef WALLACE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [9:0] exp;
        int         due;
        string      tag;
    } item_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    item_t sb[$];

    wallace_tree_reduction_if bus ();

    wallace_tree_reduction dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkDue();
        item_t it;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            checkOutput(it.tag, bus.P, it.exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [9:0] exp);
        item_t it;
        it.exp = exp;
        it.due = cyc + LAT;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic applyStimulus(input string tag, input logic [4:0] a, input logic [4:0] b,
                                 input logic [9:0] exp);
        @(negedge clk);
        checkDue();
        bus.A = a;
        bus.B = b;
        pushExp(tag, exp);
    endtask

    task automatic drain();
        repeat (LAT + 1) begin
            @(negedge clk);
            checkDue();
        end
        checkOutput("queue_empty", 10'(sb.size()), 10'd0);
    endtask

    // Reset lands while 31x31 is in flight; the discarded result must never reach P.
    task automatic doReset();
        @(negedge clk);
        checkDue();
        rst_n = 1'b0;
        bus.A = 5'd31;
        bus.B = 5'd31;
        sb.delete();
        @(negedge clk);
        checkOutput("rst_clear", bus.P, 10'd0);
        rst_n = 1'b1;
        pushExp("rst_release_31x31", 10'd961);
`ifdef WALLACE_PIPE_EN
        @(negedge clk);
        checkOutput("rst_stage_clear", bus.P, 10'd0);
`endif
    endtask

    initial begin
        logic [9:0] prod;
        bus.A = 5'd7;
        bus.B = 5'd9;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", bus.P, 10'd0);
        rst_n = 1'b1;
        pushExp("first_after_reset_7x9", 10'd63);

        applyStimulus("22x22", 5'd22, 5'd22, 10'd484);
        applyStimulus("11x31", 5'd11, 5'd31, 10'd341);
        applyStimulus("23x5", 5'd23, 5'd5, 10'd115);
        applyStimulus("10x14", 5'd10, 5'd14, 10'd140);
        applyStimulus("0x23", 5'd0, 5'd23, 10'd0);
        applyStimulus("23x0", 5'd23, 5'd0, 10'd0);
        applyStimulus("31x31", 5'd31, 5'd31, 10'd961);
        applyStimulus("1x1", 5'd1, 5'd1, 10'd1);
        applyStimulus("16x16", 5'd16, 5'd16, 10'd256);

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                prod = 10'(a * b);
                applyStimulus($sformatf("sweep_%0dx%0d", a, b), 5'(a), 5'(b), prod);
            end
        end
        drain();

        applyStimulus("pre_rst_31x31", 5'd31, 5'd31, 10'd961);
        doReset();
        applyStimulus("post_rst_10x14", 5'd10, 5'd14, 10'd140);
        applyStimulus("post_rst_22x22", 5'd22, 5'd22, 10'd484);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wallace_tree_reduction.md
WALLACE_TREE_REDUCTION -- requirements
Module: wallace_tree_reduction

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 5 bits and product width at 10 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 A  input  5  unsigned multiplicand.
REQ-006 B  input  5  unsigned multiplier.
REQ-007 P  output  10  unsigned product A*B, driven directly from a register.

Function
REQ-008 P SHALL equal A*B as an exact unsigned product; range 0..961; no truncation, no overflow.
REQ-009 Partial products SHALL be formed as pp[i][j] = A[j] AND B[i] (i,j in 0..4), weight 2^(i+j): 25 bits; initial column heights 1,2,3,4,5,4,3,2,1 for columns 0..8.
REQ-010 Reduction SHALL use only full adders (3:2) and half adders (2:2), grouping bits per Wallace rule in each stage: heights 5->4->3->2 over three reduction stages.
REQ-011 Each FA/HA sum SHALL stay in its column; each carry SHALL move to the next-higher column; no bit may be dropped.
REQ-012 After reduction, at most two bits SHALL remain per column; a 10-bit carry-propagate (ripple) adder SHALL sum the two rows to form the product.
REQ-013 Column 9 SHALL receive only the final adder carry-out.
REQ-014 The multiply SHALL be combinational from A/B to the output register input; P SHALL be loaded on every rising clk edge with rst_n high; no enable or handshake.
REQ-015 Base latency SHALL be 1 cycle: A/B present before edge k give P valid after edge k.
REQ-016 Operand changes every cycle SHALL be accepted; throughput is one product per cycle.
REQ-017 Zero on either operand SHALL give P = 0 at the normal latency.

Reset
REQ-018 With rst_n low at a rising edge, P and every internal pipeline register SHALL clear to 0.
REQ-019 Reset SHALL take priority over loading new results; a multiply in flight when reset is asserted SHALL be discarded.
REQ-020 The first edge with rst_n high SHALL load the product of the A/B then present (stage 1 of pipeline when enabled).

Configuration
REQ-021 Macro WALLACE_PIPE_EN SHALL select an extra pipeline register.
REQ-022 When WALLACE_PIPE_EN is defined: the two reduced rows SHALL be registered before the final adder; latency becomes 2 cycles; throughput remains one product per cycle; the stage register clears on reset.
REQ-023 When WALLACE_PIPE_EN is undefined: no intermediate register; latency is 1 cycle.
REQ-024 Product values SHALL be identical in both configurations; only latency differs.

Verification
REQ-025 A=22, B=22 -> P=484 (0b0111100100) after latency.
REQ-026 A=11, B=31 -> P=341; then A=23, B=5 on the next cycle -> P=115 on the following result cycle (back-to-back).
REQ-027 A=10, B=14 -> P=140; A=0, B=23 -> P=0.
REQ-028 A=31, B=31 -> P=961 (0b1111000001, max, exercises column 9 carry).
REQ-029 Assert rst_n low for one edge while A=31, B=31 is in flight -> P=0 after that edge; after release, P=961 at normal latency.
REQ-030 Exhaustive sweep of all 1024 A/B pairs in both WALLACE_PIPE_EN settings -> P equals A*B at the configured latency.
